// File: rtl/chip8_mem_arbiter.sv
// CHIP-8 main-memory arbiter: loader-only BOOT, then round-robin fetch/data RUN with burst locking.
// Optional write protection of the interpreter area (< 0x200) when CHIP8_ARB_WPROT_EN is defined.

// state   | meaning
// ST_BOOT | only the ROM loader (req bit0) may reach memory
// ST_RUN  | fetch (bit1) and data (bit2) arbitrate; loader ignored until reset
module chip8_mem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 8,
   parameter int MAX_LOCK = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in_n,
   input  logic                  boot_done_in,
   input  logic [2:0]            req_in,
   input  logic [2:0]            lock_in,
   input  logic [2:0]            we_in,
   input  logic [3*ADDR_W-1:0]   addr_in,
   input  logic [3*DATA_W-1:0]   wdata_in,
   output logic [2:0]            gnt_out,
   output logic [2:0]            rvalid_out,
   output logic [DATA_W-1:0]     rdata_out,
   output logic                  mem_en_out,
   output logic                  mem_we_out,
   output logic [ADDR_W-1:0]     mem_addr_out,
   output logic [DATA_W-1:0]     mem_wdata_out,
   input  logic [DATA_W-1:0]     mem_rdata_in,
`ifdef CHIP8_ARB_WPROT_EN
   output logic                  wprot_err_out,
`endif
   output logic                  run_out
);

   typedef enum logic {ST_BOOT, ST_RUN} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              rr_q, rr_d;
   logic [7:0]        lock_cnt_q, lock_cnt_d;
   logic [8:0]        cnt_inc;
   logic [2:0]        rvalid_q, rvalid_d;

   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              wr_block;

   // The loader never runs in RUN, so its lock request has no effect.
   logic unused_lock0;
   assign unused_lock0 = lock_in[0];

   // rr_q = 1 means data won last; reset value makes fetch win the first tie.
   always_comb begin
      gnt_out = 3'b000;
      if (state_q == ST_RUN) begin
         case (owner_q)
            OWN_FETCH: gnt_out[1] = req_in[1];
            OWN_DATA:  gnt_out[2] = req_in[2];
            default: begin
               if (req_in[1] && req_in[2]) begin
                  if (rr_q) gnt_out[1] = 1'b1;
                  else      gnt_out[2] = 1'b1;
               end else begin
                  gnt_out[1] = req_in[1];
                  gnt_out[2] = req_in[2];
               end
            end
         endcase
      end else begin
         gnt_out[0] = req_in[0];
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < 3; k++) begin
         if (gnt_out[k]) begin
            sel_we    = we_in[k];
            sel_addr  = addr_in[k*ADDR_W +: ADDR_W];
            sel_wdata = wdata_in[k*DATA_W +: DATA_W];
         end
      end
   end

`ifdef CHIP8_ARB_WPROT_EN
   localparam logic [ADDR_W-1:0] PROT_LIMIT = ADDR_W'(512);
   // Blocked writes still get gnt so the requester does not stall forever.
   assign wr_block = (state_q == ST_RUN) && sel_we &&
                     (gnt_out[1] || (gnt_out[2] && (sel_addr < PROT_LIMIT)));
`else
   assign wr_block = 1'b0;
`endif

   assign mem_en_out    = (|gnt_out) & ~wr_block;
   assign mem_we_out    = sel_we & ~wr_block;
   assign mem_addr_out  = sel_addr;
   assign mem_wdata_out = sel_wdata;
   assign rdata_out     = mem_rdata_in;
   assign rvalid_out    = rvalid_q;
   assign run_out       = (state_q == ST_RUN);

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      rvalid_d   = gnt_out & ~we_in;
      cnt_inc    = {1'b0, lock_cnt_q} + 9'd1;
      if (state_q == ST_BOOT) begin
         if (boot_done_in) state_d = ST_RUN;
      end else if (gnt_out[2:1] != 2'b00) begin
         rr_d = gnt_out[2];
         if ((lock_in[2:1] & gnt_out[2:1]) != 2'b00) begin
            if (cnt_inc >= 9'(MAX_LOCK)) begin
               owner_d    = OWN_NONE;
               lock_cnt_d = 8'd0;
            end else begin
               owner_d    = gnt_out[2] ? OWN_DATA : OWN_FETCH;
               lock_cnt_d = cnt_inc[7:0];
            end
         end else begin
            owner_d    = OWN_NONE;
            lock_cnt_d = 8'd0;
         end
      end else if (owner_q != OWN_NONE) begin
         // Owner dropped its request: nobody is granted this cycle, lock ends.
         owner_d    = OWN_NONE;
         lock_cnt_d = 8'd0;
      end
   end

`ifdef CHIP8_ARB_WPROT_EN
   logic wprot_err_q, wprot_err_d;
   assign wprot_err_d   = wprot_err_q | wr_block;
   assign wprot_err_out = wprot_err_q;
`endif

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_q     <= ST_BOOT;
         owner_q     <= OWN_NONE;
         rr_q        <= 1'b1;
         lock_cnt_q  <= 8'd0;
         rvalid_q    <= 3'b000;
`ifdef CHIP8_ARB_WPROT_EN
         wprot_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_q        <= rr_d;
         lock_cnt_q  <= lock_cnt_d;
         rvalid_q    <= rvalid_d;
`ifdef CHIP8_ARB_WPROT_EN
         wprot_err_q <= wprot_err_d;
`endif
      end
   end

endmodule
